// File: rtl/seq_mult_ctrl_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier controller.
// Holds the controller state encodings and the default operand width.
package seq_mult_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; the building block of the ripple-carry adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/ripple_adder_n.sv
// Purely combinational WIDTH-bit ripple-carry adder built from a chain of
// full_adder cells.
module ripple_adder_n #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] s,
    output logic             c_out
);

    logic [WIDTH:0] carry;

    assign carry[0] = c_in;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
        full_adder u_fa (
            .a     (a[gi]),
            .b     (b[gi]),
            .c_in  (carry[gi]),
            .s     (s[gi]),
            .c_out (carry[gi+1])
        );
    end

    assign c_out = carry[WIDTH];

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential unsigned shift-and-add multiplier: one shared WIDTH-bit adder,
// WIDTH add/shift steps per product, start/busy/done handshake.
module seq_mult_ctrl
    import seq_mult_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] q_reg;
    logic             c_reg;
    logic [CW-1:0]    cnt_reg;
    logic [2*WIDTH-1:0] p_reg;

    logic [WIDTH-1:0] sum;
    logic             sum_c;
    logic [WIDTH:0]   step_hi;
    logic [WIDTH-1:0] a_step;
    logic [WIDTH-1:0] q_step;

    ripple_adder_n #(.WIDTH(WIDTH)) u_adder (
        .a     (a_reg),
        .b     (m_reg),
        .c_in  (1'b0),
        .s     (sum),
        .c_out (sum_c)
    );

    // Add-then-shift folded into one update: {C,A} after the optional add,
    // then the whole {C,A,Q} moves right by one. C is always 0 between steps.
    assign step_hi = q_reg[0] ? {sum_c, sum} : {c_reg, a_reg};
    assign a_step  = step_hi[WIDTH:1];
    assign q_step  = {step_hi[0], q_reg[WIDTH-1:1]};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt_reg == LAST) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            m_reg     <= '0;
            a_reg     <= '0;
            q_reg     <= '0;
            c_reg     <= 1'b0;
            cnt_reg   <= '0;
            p_reg     <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        m_reg   <= a;
                        q_reg   <= b;
                        a_reg   <= '0;
                        c_reg   <= 1'b0;
                        cnt_reg <= '0;
                    end
                end
                RUN: begin
                    a_reg   <= a_step;
                    q_reg   <= q_step;
                    c_reg   <= 1'b0;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST) begin
                        p_reg <= {a_step, q_step};
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);
    assign p    = p_reg;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed bench for seq_mult_ctrl: one WIDTH=4 instance for handshake and
// exhaustive checks, one WIDTH=8 instance for random operand pairs.
module tb_seq_mult_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start4 = 1'b0;
    logic [3:0]  a4 = '0;
    logic [3:0]  b4 = '0;
    logic        busy4, done4;
    logic [7:0]  p4;
    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8, done8;
    logic [15:0] p8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_mult_ctrl #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .p(p4)
    );

    seq_mult_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .p(p8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start one WIDTH=4 multiply and check latency, product and busy at done.
    task automatic mul4(input logic [3:0] x, input logic [3:0] y, input string tag);
        int n;
        logic [7:0] expv;
        expv = 8'(x) * 8'(y);
        a4 = x; b4 = y; start4 = 1'b1;
        step();
        start4 = 1'b0;
        checks++;
        if (busy4 !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_E0 got %b want 1", tag, busy4);
        end
        n = 0;
        while (done4 !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (done4 !== 1'b1) begin
            errors++;
            $display("FAIL %s done_timeout got no done within 20 cycles", tag);
        end else begin
            if (n !== 4) begin
                errors++;
                $display("FAIL %s latency got %0d want 4", tag, n);
            end
            checks++;
            if (p4 !== expv) begin
                errors++;
                $display("FAIL %s product %0d*%0d got %0d want %0d", tag, x, y, p4, expv);
            end
            checks++;
            if (busy4 !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_in_done got %b want 0", tag, busy4);
            end
        end
        $display("mul4 %s %0d*%0d -> p=%0d", tag, x, y, p4);
    endtask

    task automatic mul8(input logic [7:0] x, input logic [7:0] y);
        int n;
        logic [15:0] expv;
        expv = 16'(x) * 16'(y);
        a8 = x; b8 = y; start8 = 1'b1;
        step();
        start8 = 1'b0;
        n = 0;
        while (done8 !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        checks++;
        if (done8 !== 1'b1) begin
            errors++;
            $display("FAIL mul8 done_timeout for %0d*%0d", x, y);
        end else if (n !== 8 || p8 !== expv) begin
            errors++;
            $display("FAIL mul8 %0d*%0d got p=%0d latency=%0d want p=%0d latency=8",
                     x, y, p8, n, expv);
        end
        $display("mul8 %0d*%0d -> p=%0d", x, y, p8);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || p4 !== 8'h00) begin
            errors++;
            $display("FAIL reset4 got busy=%b done=%b p=%h want 0 0 00", busy4, done4, p4);
        end
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || p8 !== 16'h0000) begin
            errors++;
            $display("FAIL reset8 got busy=%b done=%b p=%h want 0 0 0000", busy8, done8, p8);
        end
        $display("reset: busy4=%b done4=%b p4=%h", busy4, done4, p4);
    endtask

    task automatic test_basic();
        a4 = 4'd15; b4 = 4'd15; start4 = 1'b1;
        step();
        start4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy4 !== 1'b1 || done4 !== 1'b0) begin
                errors++;
                $display("FAIL basic_busy cycle %0d got busy=%b done=%b want 1 0", i, busy4, done4);
            end
            a4 = 4'(i); b4 = 4'(i + 3);
            step();
        end
        checks++;
        if (done4 !== 1'b1 || busy4 !== 1'b0 || p4 !== 8'hE1) begin
            errors++;
            $display("FAIL basic_done got done=%b busy=%b p=%h want 1 0 e1", done4, busy4, p4);
        end
        step();
        checks++;
        if (done4 !== 1'b0 || busy4 !== 1'b0 || p4 !== 8'hE1) begin
            errors++;
            $display("FAIL basic_after got done=%b busy=%b p=%h want 0 0 e1", done4, busy4, p4);
        end
        $display("basic 15*15 -> p=%h", p4);
    endtask

    task automatic test_hold();
        mul4(4'd0, 4'd9, "zero");
        mul4(4'd1, 4'd1, "one");
        mul4(4'd12, 4'd5, "twelve_five");
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (p4 !== 8'h3C || done4 !== 1'b0) begin
                errors++;
                $display("FAIL hold cycle %0d got p=%h done=%b want 3c 0", i, p4, done4);
            end
        end
        $display("hold p=%h", p4);
    endtask

    task automatic test_back_to_back();
        int first_done;
        int second_done;
        first_done = -1;
        second_done = -1;
        a4 = 4'd3; b4 = 4'd7; start4 = 1'b1;
        for (int c = 1; c <= 20 && second_done < 0; c++) begin
            step();
            if (done4 === 1'b1) begin
                if (first_done < 0) begin
                    first_done = c;
                    checks++;
                    if (p4 !== 8'd21) begin
                        errors++;
                        $display("FAIL b2b_first got p=%0d want 21", p4);
                    end
                    a4 = 4'd6; b4 = 4'd11;
                end else begin
                    second_done = c;
                    checks++;
                    if (p4 !== 8'd66) begin
                        errors++;
                        $display("FAIL b2b_second got p=%0d want 66", p4);
                    end
                    start4 = 1'b0;
                end
            end else if (first_done > 0) begin
                checks++;
                if (busy4 !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_gap cycle %0d got busy=%b want 1", c, busy4);
                end
            end
        end
        start4 = 1'b0;
        checks++;
        if (first_done !== 5 || second_done - first_done !== 5) begin
            errors++;
            $display("FAIL b2b_spacing got first=%0d second=%0d want 5 10", first_done, second_done);
        end
        step();
        $display("b2b done at %0d and %0d, p=%0d", first_done, second_done, p4);
    endtask

    task automatic test_run_ignore();
        a4 = 4'd10; b4 = 4'd13; start4 = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            start4 = ~start4;
            a4 = 4'($urandom_range(0, 15));
            b4 = 4'($urandom_range(0, 15));
            step();
        end
        start4 = 1'b0;
        checks++;
        if (done4 !== 1'b1 || p4 !== 8'd130) begin
            errors++;
            $display("FAIL run_ignore got done=%b p=%0d want 1 130", done4, p4);
        end
        step();
        $display("run_ignore 10*13 -> p=%0d", p4);
    endtask

    task automatic test_abort();
        int seen;
        seen = 0;
        a4 = 4'd9; b4 = 4'd9; start4 = 1'b1;
        step();
        start4 = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || p4 !== 8'h00) begin
            errors++;
            $display("FAIL abort_state got busy=%b done=%b p=%h want 0 0 00", busy4, done4, p4);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            if (done4 === 1'b1 || busy4 === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_quiet got %0d active cycles want 0", seen);
        end
        $display("abort p=%h", p4);
        mul4(4'd2, 4'd3, "after_abort");
    endtask

    task automatic test_sweep4();
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                mul4(4'(x), 4'(y), "sweep");
            end
        end
    endtask

    task automatic test_random8();
        mul8(8'hFF, 8'hFF);
        for (int i = 0; i < 200; i++) begin
            mul8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_back_to_back();
        test_run_ignore();
        test_abort();
        test_sweep4();
        test_random8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
